// File: rtl/mul_sig_seq.sv
// Sequential unsigned significand multiplier: retires DIGIT multiplier bits per
// cycle with a valid/ready handshake on both sides and registered status flags.
module mul_sig_seq #(
  parameter int WIDTH = 24,
  parameter int DIGIT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_data_one,
  input  logic [WIDTH-1:0]   i_data_two,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_data,
  output logic               o_norm,
  output logic               o_zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int PW    = 2 * WIDTH;

  generate
    if (!((DIGIT == 1) || (DIGIT == 2) || (DIGIT == 4)) || (WIDTH % DIGIT != 0)) begin : g_bad_param
      $error("mul_sig_seq: DIGIT must be 1, 2 or 4 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg;
  logic [PW-1:0]   a_sh_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]   acc_reg;
  logic [CW-1:0]   count_reg;
  logic [PW-1:0]   data_reg;
  logic            norm_reg;
  logic            zero_reg;
  logic            valid_reg;
  logic            ready_reg;
  logic [PW-1:0]   acc_next;

  // The multiplicand is pre-shifted to the current digit position, so each
  // digit contributes DIGIT shifted copies of it. Partial sums never exceed
  // the final product, so PW bits are always enough.
  logic [PW-1:0] pp_chain [DIGIT+1];
  assign pp_chain[0] = acc_reg;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_digit
      assign pp_chain[gi+1] = pp_chain[gi] + (b_reg[gi] ? (a_sh_reg << gi) : {PW{1'b0}});
    end
  endgenerate

  assign acc_next = pp_chain[DIGIT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
      data_reg  <= '0;
      norm_reg  <= 1'b0;
      zero_reg  <= 1'b0;
      valid_reg <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            a_sh_reg  <= {{WIDTH{1'b0}}, i_data_one};
            b_reg     <= i_data_two;
            acc_reg   <= '0;
            count_reg <= CW'(STEPS);
            ready_reg <= 1'b0;
            if ((i_data_one == '0) || (i_data_two == '0)) begin
              data_reg  <= '0;
              norm_reg  <= 1'b0;
              zero_reg  <= 1'b1;
              valid_reg <= 1'b1;
              state_reg <= DONE;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_reg   <= acc_next;
          a_sh_reg  <= a_sh_reg << DIGIT;
          b_reg     <= b_reg >> DIGIT;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            data_reg  <= acc_next;
            norm_reg  <= acc_next[PW-1];
            zero_reg  <= 1'b0;
            valid_reg <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // Product registers are left untouched so they remain readable.
          if (i_ready) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = ready_reg;
  assign o_valid = valid_reg;
  assign o_data  = data_reg;
  assign o_norm  = norm_reg;
  assign o_zero  = zero_reg;

endmodule
